pset00_inverter_unit: RTL and testbench

Parameterised inverter and buffer block for problem set 00, covering the original combinational inverter and the buffer test module. It provides a zero-latency inverted output and a zero-latency pass-through output for any input, including a clock-like signal. It also provides a registered inverted copy and an input-toggle counter for bench observability. It sits directly on a free-running stimulus net and is the reference leaf cell for the problem-set flow.

---
 rtl/pset00_inverter_unit.sv | 51 +++++
 tb/tb_pset00_inverter_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pset00_inverter_unit.sv
// Inverter/buffer leaf cell: zero-latency inverted and pass-through outputs,
// plus a registered inverted copy and a saturating input-toggle counter.
`timescale 1ns/1ps

module pset00_inverter_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] buf_out,
    output logic [WIDTH-1:0] out_q,
    output logic [CNT_W-1:0] toggle_cnt
);

    // Counter holds at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [WIDTH-1:0] inv_q,  inv_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    assign out     = ~in;
    assign buf_out = in;

    always_comb begin
        inv_d  = ~in;
        prev_d = in;
        cnt_d  = (in != prev_q) ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q  <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            inv_q  <= inv_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_q      = inv_q;
    assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_pset00_inverter_unit.sv
// Bench for pset00_inverter_unit: an 8-bit and a 1-bit/4-bit-counter instance
// checked against a sampled-value model, plus a 1-bit instance on a fast clock-like net.
`timescale 1ns/1ps

module tb_pset00_inverter_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fclk = 1'b0;
    logic [7:0]  in8 = 8'h00;
    logic        in1 = 1'b0;

    logic [7:0]  out8, buf8, q8;
    logic [15:0] cnt8;
    logic        out1, buf1, q1;
    logic [3:0]  cnt1;
    logic        outc, bufc, qc;
    logic [3:0]  cntc;

    int total = 0;
    int bad = 0;

    logic [7:0] m_prev8;
    int         m_cnt8;
    logic [7:0] m_q8;
    logic       m_prev1;
    int         m_cnt1;
    logic       m_q1;

    always #5 clk = ~clk;

    pset00_inverter_unit #(.WIDTH(8), .CNT_W(16)) u8 (
        .clk(clk), .rst_n(rst_n), .in(in8),
        .out(out8), .buf_out(buf8), .out_q(q8), .toggle_cnt(cnt8)
    );

    pset00_inverter_unit #(.WIDTH(1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in(in1),
        .out(out1), .buf_out(buf1), .out_q(q1), .toggle_cnt(cnt1)
    );

    pset00_inverter_unit #(.WIDTH(1), .CNT_W(4)) uc (
        .clk(clk), .rst_n(rst_n), .in(fclk),
        .out(outc), .buf_out(bufc), .out_q(qc), .toggle_cnt(cntc)
    );

    // One clock cycle: drive at negedge (optionally glitching first), check
    // combinational outputs, then check registered outputs just after posedge.
    task automatic tick(input logic [7:0] v8, input logic v1, input bit glitch);
        @(negedge clk);
        if (glitch) begin
            in8 = 8'($urandom);
            in1 = 1'($urandom);
            #1;
        end
        in8 = v8;
        in1 = v1;
        #1;
        total++; if (out8 !== ~v8) begin bad++; $display("FAIL comb_out8 got=%h exp=%h", out8, ~v8); end
        total++; if (buf8 !== v8) begin bad++; $display("FAIL comb_buf8 got=%h exp=%h", buf8, v8); end
        total++; if (out1 !== ~v1) begin bad++; $display("FAIL comb_out1 got=%b exp=%b", out1, ~v1); end
        @(posedge clk);
        #1;
        if (v8 != m_prev8) m_cnt8 = (m_cnt8 < 65535) ? m_cnt8 + 1 : m_cnt8;
        m_prev8 = v8;
        m_q8 = ~v8;
        if (v1 != m_prev1) m_cnt1 = (m_cnt1 < 15) ? m_cnt1 + 1 : m_cnt1;
        m_prev1 = v1;
        m_q1 = ~v1;
        total++; if (q8 !== m_q8) begin bad++; $display("FAIL out_q8 got=%h exp=%h", q8, m_q8); end
        total++; if (cnt8 !== 16'(m_cnt8)) begin bad++; $display("FAIL cnt8 got=%0d exp=%0d", cnt8, m_cnt8); end
        total++; if (q1 !== m_q1) begin bad++; $display("FAIL out_q1 got=%b exp=%b", q1, m_q1); end
        total++; if (cnt1 !== 4'(m_cnt1)) begin bad++; $display("FAIL cnt1 got=%0d exp=%0d", cnt1, m_cnt1); end
    endtask

    // Pulse reset between edges, changing inputs while it is held.
    task automatic pulse_reset(input logic [7:0] v8, input logic v1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #0.5;
        total++; if (q8 !== 8'h00) begin bad++; $display("FAIL rst_q8 got=%h exp=00", q8); end
        total++; if (cnt8 !== 16'd0) begin bad++; $display("FAIL rst_cnt8 got=%0d exp=0", cnt8); end
        total++; if (q1 !== 1'b0) begin bad++; $display("FAIL rst_q1 got=%b exp=0", q1); end
        total++; if (cnt1 !== 4'd0) begin bad++; $display("FAIL rst_cnt1 got=%0d exp=0", cnt1); end
        in8 = v8;
        in1 = v1;
        #0.5;
        total++; if (out8 !== ~v8) begin bad++; $display("FAIL rst_out8 got=%h exp=%h", out8, ~v8); end
        total++; if (buf8 !== v8) begin bad++; $display("FAIL rst_buf8 got=%h exp=%h", buf8, v8); end
        total++; if (buf1 !== v1) begin bad++; $display("FAIL rst_buf1 got=%b exp=%b", buf1, v1); end
        // Spans a rising edge: registers must stay cleared while reset is low.
        #6;
        total++; if (cnt8 !== 16'd0 || q8 !== 8'h00) begin bad++; $display("FAIL rst_hold8 got=%0d/%h exp=0/00", cnt8, q8); end
        @(negedge clk);
        rst_n = 1'b1;
        m_prev8 = 8'h00; m_cnt8 = 0; m_q8 = 8'h00;
        m_prev1 = 1'b0;  m_cnt1 = 0; m_q1 = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (q8 !== 8'h00) begin bad++; $display("FAIL init_q8 got=%h exp=00", q8); end
        total++; if (cnt8 !== 16'd0) begin bad++; $display("FAIL init_cnt8 got=%0d exp=0", cnt8); end
        total++; if (cnt1 !== 4'd0) begin bad++; $display("FAIL init_cnt1 got=%0d exp=0", cnt1); end
        total++; if (out8 !== 8'hFF) begin bad++; $display("FAIL init_out8 got=%h exp=ff", out8); end
        @(negedge clk);
        rst_n = 1'b1;
        m_prev8 = 8'h00; m_cnt8 = 0; m_q8 = 8'h00;
        m_prev1 = 1'b0;  m_cnt1 = 0; m_q1 = 1'b0;
    endtask

    task automatic test_static_w1();
        tick(8'h00, 1'b0, 1'b0);
        total++; if (out1 !== 1'b1 || buf1 !== 1'b0) begin bad++; $display("FAIL w1_zero got=%b%b exp=10", out1, buf1); end
        tick(8'h00, 1'b1, 1'b0);
        total++; if (out1 !== 1'b0 || buf1 !== 1'b1) begin bad++; $display("FAIL w1_one got=%b%b exp=01", out1, buf1); end
    endtask

    task automatic test_a5();
        tick(8'hA5, 1'b0, 1'b0);
        total++; if (out8 !== 8'h5A) begin bad++; $display("FAIL a5_out got=%h exp=5a", out8); end
        total++; if (buf8 !== 8'hA5) begin bad++; $display("FAIL a5_buf got=%h exp=a5", buf8); end
        total++; if (q8 !== 8'h5A) begin bad++; $display("FAIL a5_outq got=%h exp=5a", q8); end
    endtask

    task automatic test_toggle_count();
        pulse_reset(8'h00, 1'b0);
        for (int i = 0; i < 10; i++) tick((i % 2 == 0) ? 8'h01 : 8'h00, 1'b0, 1'b0);
        total++; if (cnt8 !== 16'd10) begin bad++; $display("FAIL toggle10 got=%0d exp=10", cnt8); end
        for (int i = 0; i < 5; i++) tick(8'h00, 1'b0, 1'b0);
        total++; if (cnt8 !== 16'd10) begin bad++; $display("FAIL toggle_hold got=%0d exp=10", cnt8); end
    endtask

    task automatic test_saturate();
        pulse_reset(8'h00, 1'b0);
        for (int i = 0; i < 20; i++) tick(8'h00, (i % 2 == 0), 1'b0);
        total++; if (cnt1 !== 4'd15) begin bad++; $display("FAIL saturate got=%0d exp=15", cnt1); end
    endtask

    task automatic test_random();
        logic [7:0] v8;
        logic       v1;
        for (int i = 0; i < 60; i++) begin
            v8 = ($urandom_range(0, 3) == 0) ? m_prev8 : 8'($urandom);
            v1 = 1'($urandom);
            tick(v8, v1, ($urandom_range(0, 2) == 0));
        end
    endtask

    task automatic test_reset_mid();
        tick(8'h3C, 1'b1, 1'b0);
        pulse_reset(8'hC3, 1'b1);
        tick(8'hC3, 1'b1, 1'b0);
        total++; if (cnt8 !== 16'd1) begin bad++; $display("FAIL post_rst_first got=%0d exp=1", cnt8); end
    endtask

    task automatic test_clock_like();
        for (int i = 0; i < 10; i++) begin
            fclk = ~fclk;
            #0.3;
            total++; if (outc !== ~fclk) begin bad++; $display("FAIL clk_out got=%b exp=%b", outc, ~fclk); end
            total++; if (bufc !== fclk) begin bad++; $display("FAIL clk_buf got=%b exp=%b", bufc, fclk); end
            #0.7;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_static_w1();
        test_a5();
        test_toggle_count();
        test_saturate();
        test_random();
        test_reset_mid();
        test_clock_like();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
